// File: rtl/data_mem_ws.sv
// data_mem_ws: MEM-stage data memory with byte/half/word access, little-endian
// lanes, sign/zero-extended loads and a fixed number of wait states.
// A request is accepted in IDLE, and its inputs are latched at that edge.
// Misaligned or out-of-range requests complete with fault=1 and leave memory untouched.
// Optional feature macro: DATA_MEM_WS_PRELOAD_EN. When it is defined, a fixed
// table is preloaded at byte addresses 1000..1036 and every other word starts at 0.
module data_mem_ws #(
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        done,
    output logic        fault
);

    localparam int DEPTH = 1 << (ADDR_W - 2);
    localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t             state_q;
    logic [2:0]         cnt_q;
    logic               wr_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        read_data_q;
    logic               done_q;
    logic               fault_q;
    logic [31:0]        mem_q [DEPTH];

    logic               req_s;
    logic               wr_s;
    logic               fault_s;
    logic               acc_now_s;
    logic               acc_wr_s;
    logic [1:0]         acc_size_s;
    logic               acc_uns_s;
    logic [ADDR_W-1:0]  acc_addr_s;
    logic [31:0]        acc_wdata_s;
    logic [3:0]         be_s;
    logic [31:0]        wlanes_s;
    logic [31:0]        rd_word_s;
    logic [31:0]        load_d;
    logic               mem_we_s;

    // A misaligned or out-of-range address is a fault. A size code of 11 is checked as a word.
    function automatic logic access_fault(input logic [1:0] sz, input logic [31:0] a);
        logic f;
        case (sz)
            2'b00:   f = 1'b0;
            2'b01:   f = a[0];
            default: f = (a[1:0] != 2'b00);
        endcase
        return f | ((a >> ADDR_W) != 32'd0);
    endfunction

    // Per-lane write enables for a store
    function automatic logic [3:0] lane_enable(input logic [1:0] sz, input logic [1:0] lane);
        logic [3:0] be;
        case (sz)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Copy right-justified store data into every lane it can land in
    function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] d;
        case (sz)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Select the addressed lane(s) of a word, then sign- or zero-extend
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Decode the request. Take access fields from the inputs in IDLE and from the latched copy otherwise.
    always_comb begin
        req_s    = mem_read | mem_write;
        wr_s     = mem_write & ~mem_read;
        fault_s  = access_fault(size, address);
        if (state_q == IDLE) begin
            acc_wr_s    = wr_s;
            acc_size_s  = size;
            acc_uns_s   = unsigned_ld;
            acc_addr_s  = address[ADDR_W-1:0];
            acc_wdata_s = write_data;
            acc_now_s   = (WAIT_STATES == 0) & req_s & ~fault_s;
        end else begin
            acc_wr_s    = wr_q;
            acc_size_s  = size_q;
            acc_uns_s   = uns_q;
            acc_addr_s  = addr_q;
            acc_wdata_s = wdata_q;
            acc_now_s   = (state_q == BUSY) & (cnt_q == 3'd0);
        end
        be_s      = lane_enable(acc_size_s, acc_addr_s[1:0]);
        wlanes_s  = lane_data(acc_size_s, acc_wdata_s);
        rd_word_s = mem_q[acc_addr_s[ADDR_W-1:2]];
        load_d    = load_extend(rd_word_s, acc_size_s, acc_addr_s[1:0], acc_uns_s);
        mem_we_s  = acc_now_s & acc_wr_s & rst_n;
    end

    // Hold the pipeline while a request waits in IDLE or while it is BUSY
    assign stall     = ((state_q == IDLE) & req_s & rst_n) | (state_q == BUSY);
    assign read_data = read_data_q;
    assign done      = done_q;
    assign fault     = fault_q;

`ifdef DATA_MEM_WS_PRELOAD_EN
    // Time-zero image: table at byte 1000 onward, every other word zero
    initial begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] = 32'd0;
        mem_q[250] = 32'd56; mem_q[251] = 32'd5; mem_q[252] = 32'd4; mem_q[253] = 32'd6;
        mem_q[254] = 32'd2;  mem_q[255] = 32'd5; mem_q[256] = 32'd4; mem_q[257] = 32'd8;
        mem_q[258] = 32'd4;  mem_q[259] = 32'd5;
    end
`else
`endif

    // Storage array with per-lane write enables. Reset does not clear it.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_we_s && be_s[k]) begin
                mem_q[acc_addr_s[ADDR_W-1:2]][8*k +: 8] <= wlanes_s[8*k +: 8];
            end
        end
    end

    // Access sequencer: accept in IDLE, count wait states in BUSY, pulse done in DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            wr_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            read_data_q <= 32'd0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                    if (req_s) begin
                        wr_q    <= wr_s;
                        size_q  <= size;
                        uns_q   <= unsigned_ld;
                        addr_q  <= address[ADDR_W-1:0];
                        wdata_q <= write_data;
                        if (fault_s) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            fault_q     <= 1'b1;
                            read_data_q <= 32'd0;
                        end else if (WAIT_STATES == 0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            if (!wr_s) read_data_q <= load_d;
                        end else begin
                            cnt_q   <= CNT_INIT;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        if (!wr_q) read_data_q <= load_d;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/data_mem_ws.md
# data_mem_ws

Parametrised, clocked data memory for the MEM stage of the MIPS pipeline. Supports byte, halfword and word loads and stores with little-endian lanes, and sign/zero extension on loads. A programmable number of wait states models slow memory; a `stall` output holds the pipeline while an access is pending. Misaligned and out-of-range accesses are reported as faults and never modify memory.

## Interface
- `ADDR_W`, 16: byte-address bits decoded; the memory holds 2^(ADDR_W-2) 32-bit words.
- `WAIT_STATES`, 1: extra busy cycles per access, 0..7.
- `clk` in 1: clock, all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `mem_read` in 1: load request.
- `mem_write` in 1: store request.
- `size` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `unsigned_ld` in 1: 1 = zero-extend byte/half loads, 0 = sign-extend.
- `address` in 32: byte address.
- `write_data` in 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `read_data` out 32: registered load result.
- `stall` out 1: pipeline hold; request pending.
- `done` out 1: one-cycle pulse, access complete.
- `fault` out 1: valid with `done`; access was misaligned or out of range.

## Operation
- States: IDLE, BUSY, DONE. The counter is 3 bits.
- Request = `mem_read | mem_write`. If both are high, the request is a load and the write is ignored.
- IDLE:
  - No request: stay in IDLE.
  - Faulting request: go to DONE with `fault`=1.
  - `WAIT_STATES`=0: perform the access at this edge and go to DONE.
  - Otherwise: load the counter with `WAIT_STATES`-1 and go to BUSY.
- BUSY: decrement the counter each cycle. In the cycle the counter is 0, perform the access at the edge and go to DONE.
- DONE: go to IDLE unconditionally. The request is not re-sampled in DONE; the pipeline advances at the end of the DONE cycle.
- Fault conditions (checked in IDLE):
  - half with `address[0]`=1;
  - word with `address[1:0]`≠0;
  - `address[31:ADDR_W]`≠0.
- Fault response: no memory write, and `read_data` is set to 0.
- Word index = `address[ADDR_W-1:2]`. Lane = `address[1:0]`; byte lane k is bits [8k+7:8k].
- Stores:
  - Byte writes lane `address[1:0]` only.
  - Half writes lanes {`address[1]`*2, +1}.
  - Word writes all four lanes.
  - Other lanes are unchanged (per-lane write enable).
- Loads: select the lane(s), then extend per `unsigned_ld`, and register the result into `read_data`.
- `read_data` holds its last load value across stores and idle cycles.
- Inputs must stay stable while `stall`=1; changes during BUSY are ignored. The access uses the values sampled in IDLE, which are registered at acceptance.
- Memory array contents are not affected by reset.

## Timing
- `stall` = (IDLE & request & `rst_n`) | BUSY. It is combinational from the inputs in IDLE.
- A request first seen in cycle 0 gives:
  - `stall`=1 for cycles 0..`WAIT_STATES`;
  - `done`=1, `stall`=0 and `read_data` valid in cycle `WAIT_STATES`+1.
- Fault: `stall`=1 in cycle 0 only; `done`=`fault`=1 in cycle 1.
- Back-to-back accesses cost `WAIT_STATES`+2 cycles each; there is a mandatory IDLE re-sample after DONE.
- Reset values: state IDLE, counter 0, `read_data`=0, `done`=0, `fault`=0, `stall`=0.
- Reset asserted during BUSY: a pending store is not performed, and the block is in IDLE on the cycle after `rst_n` rises.

## Configuration
- Macro: `DATA_MEM_WS_PRELOAD_EN`.
- Defined: the array is initialised at time 0 with words 56, 5, 4, 6, 2, 5, 4, 8, 4, 5 at byte addresses 1000, 1004, …, 1036; all other words are 0.
- Undefined: no initialisation; contents are X until written. Benches must store before they load.

## Test plan
- `WAIT_STATES`=1, preload on, word load @1000 → `stall` high for 2 cycles, then `done`=1, `read_data`=56, `fault`=0.
- Store word 0x80FF7F01 @2000, then byte loads @2000..2003 with `unsigned_ld`=0 → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; the same loads with `unsigned_ld`=1 → 0x01, 0x7F, 0xFF, 0x80.
- Store half 0xBEEF @2002 over word 0x11223344 @2000, then word load → 0xBEEF3344; signed half load @2002 → 0xFFFFBEEF.
- Word load @1002 and half store @1001 → each gives `done`=`fault`=1 in cycle 1 and `read_data`=0; word load @1000 afterwards still returns 56.
- `WAIT_STATES`=3, store 0xAAAA5555 @3000, `rst_n` low in the second BUSY cycle → all outputs 0, back in IDLE after reset; load @3000 returns the prior content, not 0xAAAA5555.
- `WAIT_STATES`=0 with `mem_read`=`mem_write`=1 @1004 → load is performed, `read_data`=5, memory unchanged; `stall` lasts exactly 1 cycle.
